erase_queue_ctrl: RTL and testbench
===================================

ERASE_QUEUE_CTRL -- requirements
Module: erase_queue_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning request FIFO entries; power of 2, 2..16.
REQ-002 SHALL have parameter SETTLE, default 3, meaning cycles after eraser release before plot asserts.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  in  1  erase request strobe.
REQ-006 SHALL have ports req_x  in  4  and req_y  in  4, the grid column and row of the request.
REQ-007 SHALL have port req_ready  out  1  high when the FIFO can accept a request.
REQ-008 SHALL have port erase_done  in  1  completion flag from the downstream square eraser.
REQ-009 SHALL have port eraser_resetn  out  1  active-low reset driven to the square eraser.
REQ-010 SHALL have ports grid_x  out  4  and grid_y  out  4, the square currently being erased.
REQ-011 SHALL have port plot  out  1  VGA write enable for the eraser's x/y/colour.
REQ-012 SHALL have port busy  out  1  high whenever the FSM is not in IDLE or the FIFO is non-empty.
REQ-013 SHALL have port req_err  out  1  one-cycle pulse on a rejected request.

Function
REQ-014 SHALL accept a request on a rising edge where req_valid and req_ready are both 1, pushing {req_x, req_y} into the FIFO.
REQ-015 SHALL drive req_ready as the registered FIFO not-full flag; a push while full SHALL be ignored, with no overwrite.
REQ-016 SHALL allow a push and a pop on the same edge, with count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-017 SHALL implement the FSM IDLE -> LOAD -> ERASE -> DONE -> IDLE.
REQ-018 In IDLE, with FIFO non-empty, the FSM SHALL go to LOAD on the next edge; otherwise it SHALL stay in IDLE.
REQ-019 In LOAD (one cycle), the FSM SHALL register the FIFO head into grid_x/grid_y and hold eraser_resetn=0 to clear eraser counters.
REQ-020 In ERASE, eraser_resetn SHALL be 1; a settle counter SHALL count SETTLE cycles with plot=0, then plot SHALL be 1 every cycle.
REQ-021 In ERASE, plot SHALL remain 1 in the first cycle erase_done is sampled high, covering the final pixel (19,19).
REQ-022 On that edge the FSM SHALL pop the FIFO and go to DONE.
REQ-023 In DONE (one cycle), the block SHALL drive plot=0 and eraser_resetn=0, then go to IDLE.
REQ-024 A request pushed into an empty, idle queue at edge N SHALL give LOAD after edge N+1 and ERASE after edge N+2.
REQ-025 grid_x/grid_y SHALL change only in LOAD.
REQ-026 erase_done SHALL be ignored outside ERASE and during settle cycles.

Reset
REQ-027 When resetn=0 at a clock edge, the block SHALL abort any erase, clear the FIFO, and enter IDLE, regardless of state.
REQ-028 Reset values SHALL be: req_ready=1, eraser_resetn=0, grid_x=0, grid_y=0, plot=0, busy=0, req_err=0.
REQ-029 No push SHALL be accepted on an edge where resetn=0.

Configuration
REQ-030 With ERASE_BOUNDS_CHECK_EN defined, an accepted-handshake request with req_x>7 or req_y>5 (outside the 160x120 map of 8x6 squares) SHALL NOT be pushed, and req_err SHALL pulse for one cycle.
REQ-031 Without ERASE_BOUNDS_CHECK_EN, all requests SHALL be pushed and req_err SHALL be tied to 0.

Verification
REQ-032 Reset, then a single request (3,2): LOAD after 2 edges; grid=(3,2); plot low 3 cycles, then high until erase_done is sampled, including that cycle; then DONE and IDLE; busy then falls.
REQ-033 Five back-to-back requests at DEPTH=4 while the FSM stalls in ERASE: req_ready falls after the 4th push; the 5th is dropped; four erases complete in FIFO order.
REQ-034 Push coinciding with the pop edge on a full FIFO: the push is rejected; on a 3-entry FIFO the push is accepted and count stays 3.
REQ-035 resetn low mid-ERASE (settle passed, plot=1): next cycle plot=0, eraser_resetn=0, FIFO empty, req_ready=1.
REQ-036 With ERASE_BOUNDS_CHECK_EN, request (8,0): req_err pulses one cycle, FIFO stays empty; request (7,5) is accepted normally. Without the macro, (8,0) is erased with req_err=0.

Source files
------------

// File: rtl/erase_queue_ctrl.sv
// erase_queue_ctrl
//    Queues square-erase requests and sequences the downstream square eraser
//    one square at a time: load the square's grid position, release the
//    eraser from reset, wait a short settle period, then enable VGA plotting
//    until the eraser reports completion.
//
// Parameters
//    DEPTH   request FIFO entries (power of 2, 2..16)
//    SETTLE  cycles after eraser release before plot asserts
//
// Ports
//    clk            rising-edge clock
//    resetn         synchronous, active-low reset
//    req_valid      erase request strobe
//    req_x, req_y   grid column / row of the request
//    req_ready      FIFO can accept a request (registered not-full)
//    erase_done     completion flag from the square eraser
//    eraser_resetn  active-low reset to the square eraser
//    grid_x, grid_y square currently being erased
//    plot           VGA write enable for the eraser's pixel stream
//    busy           FSM not idle or FIFO non-empty
//    req_err        one-cycle pulse on a rejected (out-of-map) request
//
// Build option
//    ERASE_BOUNDS_CHECK_EN  reject requests outside the 8x6 square map
//                           (req_x > 7 or req_y > 5) and pulse req_err.
//                           Undefined: every request is queued, req_err = 0.
//
// State table
//    state   | meaning
//    IDLE    | waiting for a queued request
//    LOAD    | latch FIFO head into grid_x/grid_y, eraser held in reset
//    ERASE   | eraser running; settle countdown, then plot every cycle
//    DONE    | one-cycle gap, eraser back in reset, plot off

module erase_queue_ctrl #(
   parameter int DEPTH  = 4,
   parameter int SETTLE = 3
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       req_valid,
   input  logic [3:0] req_x,
   input  logic [3:0] req_y,
   output logic       req_ready,
   input  logic       erase_done,
   output logic       eraser_resetn,
   output logic [3:0] grid_x,
   output logic [3:0] grid_y,
   output logic       plot,
   output logic       busy,
   output logic       req_err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_ERASE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          full_q, full_d;

   state_t        state_q, state_d;
   logic [CW-1:0] settle_q, settle_d;
   logic [3:0]    grid_x_q, grid_x_d;
   logic [3:0]    grid_y_q, grid_y_d;

   logic          req_ok;
   logic          push;
   logic          pop;
   logic          settle_done;
   logic [7:0]    head;

`ifdef ERASE_BOUNDS_CHECK_EN
   logic          req_err_q, req_err_d;

   assign req_ok    = (req_x <= 4'd7) && (req_y <= 4'd5);
   assign req_err_d = req_valid && !full_q && !req_ok;
   assign req_err   = req_err_q;
`else
   assign req_ok    = 1'b1;
   assign req_err   = 1'b0;
`endif

   assign req_ready   = !full_q;
   assign push        = req_valid && !full_q && req_ok;
   assign settle_done = (settle_q == '0);
   // Pop coincides with the last plotted pixel: the edge that samples
   // erase_done after settle has elapsed.
   assign pop         = (state_q == S_ERASE) && settle_done && erase_done;
   assign head        = mem_q[rd_ptr_q];

   assign grid_x = grid_x_q;
   assign grid_y = grid_y_q;
   assign busy   = (state_q != S_IDLE) || (count_q != '0);

   // request FIFO
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = {req_x, req_y};
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
      full_d = (count_d == (AW+1)'(DEPTH));
   end

   // sequencing FSM
   always_comb begin
      state_d       = state_q;
      settle_d      = settle_q;
      grid_x_d      = grid_x_q;
      grid_y_d      = grid_y_q;
      plot          = 1'b0;
      eraser_resetn = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            grid_x_d = head[7:4];
            grid_y_d = head[3:0];
            settle_d = CW'(SETTLE);
            state_d  = S_ERASE;
         end
         S_ERASE: begin
            eraser_resetn = 1'b1;
            if (!settle_done) begin
               settle_d = settle_q - CW'(1);
            end else begin
               plot = 1'b1;
               if (erase_done) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         state_q  <= S_IDLE;
         settle_q <= '0;
         grid_x_q <= '0;
         grid_y_q <= '0;
`ifdef ERASE_BOUNDS_CHECK_EN
         req_err_q <= 1'b0;
`endif
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         state_q  <= state_d;
         settle_q <= settle_d;
         grid_x_q <= grid_x_d;
         grid_y_q <= grid_y_d;
`ifdef ERASE_BOUNDS_CHECK_EN
         req_err_q <= req_err_d;
`endif
      end
   end

endmodule

// File: tb/tb_erase_queue_ctrl.sv
// tb_erase_queue_ctrl
//    Directed bench for erase_queue_ctrl at DEPTH=4, SETTLE=3. A vector table
//    walks reset and one complete erase cycle by cycle; hand-written sequences
//    cover FIFO full/drop, push on the pop edge, reset mid-erase and the
//    optional bounds check (ERASE_BOUNDS_CHECK_EN).

module tb_erase_queue_ctrl;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       req_valid = 1'b0;
   logic [3:0] req_x = '0;
   logic [3:0] req_y = '0;
   logic       req_ready;
   logic       erase_done = 1'b0;
   logic       eraser_resetn;
   logic [3:0] grid_x;
   logic [3:0] grid_y;
   logic       plot;
   logic       busy;
   logic       req_err;

   int checks   = 0;
   int failures = 0;

   erase_queue_ctrl #(.DEPTH(4), .SETTLE(3)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .req_valid     (req_valid),
      .req_x         (req_x),
      .req_y         (req_y),
      .req_ready     (req_ready),
      .erase_done    (erase_done),
      .eraser_resetn (eraser_resetn),
      .grid_x        (grid_x),
      .grid_y        (grid_y),
      .plot          (plot),
      .busy          (busy),
      .req_err       (req_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst_n;
      logic       vld;
      logic [3:0] x;
      logic [3:0] y;
      logic       done;
      logic       e_ready;
      logic       e_ern;
      logic       e_plot;
      logic       e_busy;
      logic [3:0] e_gx;
      logic [3:0] e_gy;
      logic       e_err;
   } vec_t;

   localparam int NV = 10;
   vec_t vecs [NV];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, want);
      end
   endtask

   task automatic wait_plot(input string tag);
      int n = 0;
      while (plot !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk({tag, " plot_wait"}, {7'd0, plot}, 8'd1);
   endtask

   task automatic do_erase(input logic [3:0] ex, input logic [3:0] ey, input string tag);
      wait_plot(tag);
      chk({tag, " grid_x"}, {4'd0, grid_x}, {4'd0, ex});
      chk({tag, " grid_y"}, {4'd0, grid_y}, {4'd0, ey});
      erase_done = 1'b1;
      step();
      erase_done = 1'b0;
      chk({tag, " done_plot"}, {7'd0, plot}, 8'd0);
      chk({tag, " done_ern"}, {7'd0, eraser_resetn}, 8'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //          rst vld x     y     done | rdy ern plot busy gx    gy    err
      vecs[0] = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 4'd3, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 4'd2, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 4'd2, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 4'd2, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 4'd2, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 4'd2, 1'b0};
      vecs[8] = '{1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 4'd2, 1'b0};
      vecs[9] = '{1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd2, 1'b0};

      #2;
      // reset + single request (3,2), cycle by cycle
      for (int i = 0; i < NV; i++) begin
         resetn     = vecs[i].rst_n;
         req_valid  = vecs[i].vld;
         req_x      = vecs[i].x;
         req_y      = vecs[i].y;
         erase_done = vecs[i].done;
         step();
         chk($sformatf("v%0d req_ready", i), {7'd0, req_ready}, {7'd0, vecs[i].e_ready});
         chk($sformatf("v%0d eraser_resetn", i), {7'd0, eraser_resetn}, {7'd0, vecs[i].e_ern});
         chk($sformatf("v%0d plot", i), {7'd0, plot}, {7'd0, vecs[i].e_plot});
         chk($sformatf("v%0d busy", i), {7'd0, busy}, {7'd0, vecs[i].e_busy});
         chk($sformatf("v%0d grid_x", i), {4'd0, grid_x}, {4'd0, vecs[i].e_gx});
         chk($sformatf("v%0d grid_y", i), {4'd0, grid_y}, {4'd0, vecs[i].e_gy});
         chk($sformatf("v%0d req_err", i), {7'd0, req_err}, {7'd0, vecs[i].e_err});
      end
      req_valid  = 1'b0;
      erase_done = 1'b0;

      // five back-to-back requests, fifth dropped on full FIFO
      for (int k = 0; k < 5; k++) begin
         req_valid = 1'b1;
         req_x     = 4'(k + 1);
         req_y     = 4'd1;
         step();
         chk($sformatf("b2b%0d req_ready", k), {7'd0, req_ready}, (k >= 3) ? 8'd0 : 8'd1);
         chk($sformatf("b2b%0d plot", k), {7'd0, plot}, 8'd0);
      end
      req_valid = 1'b0;
      do_erase(4'd1, 4'd1, "b2b_e1");
      do_erase(4'd2, 4'd1, "b2b_e2");
      do_erase(4'd3, 4'd1, "b2b_e3");
      do_erase(4'd4, 4'd1, "b2b_e4");
      step();
      chk("b2b busy_after", {7'd0, busy}, 8'd0);

      // push on the pop edge with a full FIFO: rejected
      for (int k = 0; k < 4; k++) begin
         req_valid = 1'b1;
         req_x     = 4'(k + 1);
         req_y     = 4'd2;
         step();
      end
      req_valid = 1'b0;
      chk("full req_ready", {7'd0, req_ready}, 8'd0);
      wait_plot("full");
      req_valid  = 1'b1;
      req_x      = 4'd6;
      req_y      = 4'd3;
      erase_done = 1'b1;
      step();
      req_valid  = 1'b0;
      erase_done = 1'b0;
      chk("full pop req_ready", {7'd0, req_ready}, 8'd1);
      chk("full pop plot", {7'd0, plot}, 8'd0);
      do_erase(4'd2, 4'd2, "full_e2");
      do_erase(4'd3, 4'd2, "full_e3");
      do_erase(4'd4, 4'd2, "full_e4");
      step();
      chk("full busy_after", {7'd0, busy}, 8'd0);

      // push on the pop edge with 3 entries: accepted, count stays 3
      for (int k = 0; k < 3; k++) begin
         req_valid = 1'b1;
         req_x     = 4'(k + 1);
         req_y     = 4'd3;
         step();
      end
      req_valid = 1'b0;
      wait_plot("three");
      req_valid  = 1'b1;
      req_x      = 4'd5;
      req_y      = 4'd4;
      erase_done = 1'b1;
      step();
      req_valid  = 1'b0;
      erase_done = 1'b0;
      chk("three pop req_ready", {7'd0, req_ready}, 8'd1);
      do_erase(4'd2, 4'd3, "three_e2");
      do_erase(4'd3, 4'd3, "three_e3");
      do_erase(4'd5, 4'd4, "three_e5");
      step();
      chk("three busy_after", {7'd0, busy}, 8'd0);

      // reset mid-ERASE with plot high; push offered on the reset edge
      for (int k = 0; k < 2; k++) begin
         req_valid = 1'b1;
         req_x     = 4'(k + 1);
         req_y     = 4'd4;
         step();
      end
      req_valid = 1'b0;
      wait_plot("rst");
      resetn    = 1'b0;
      req_valid = 1'b1;
      req_x     = 4'd3;
      req_y     = 4'd3;
      step();
      req_valid = 1'b0;
      chk("rst plot", {7'd0, plot}, 8'd0);
      chk("rst eraser_resetn", {7'd0, eraser_resetn}, 8'd0);
      chk("rst req_ready", {7'd0, req_ready}, 8'd1);
      chk("rst busy", {7'd0, busy}, 8'd0);
      chk("rst grid_x", {4'd0, grid_x}, 8'd0);
      resetn = 1'b1;
      step();
      step();
      step();
      chk("rst busy_later", {7'd0, busy}, 8'd0);
      chk("rst ern_later", {7'd0, eraser_resetn}, 8'd0);

      // out-of-map request (8,0), then corner (7,5)
      req_valid = 1'b1;
      req_x     = 4'd8;
      req_y     = 4'd0;
      step();
      req_valid = 1'b0;
`ifdef ERASE_BOUNDS_CHECK_EN
      chk("oob req_err", {7'd0, req_err}, 8'd1);
      chk("oob busy", {7'd0, busy}, 8'd0);
      step();
      chk("oob req_err_clear", {7'd0, req_err}, 8'd0);
      chk("oob busy_later", {7'd0, busy}, 8'd0);
`else
      chk("oob req_err", {7'd0, req_err}, 8'd0);
      chk("oob busy", {7'd0, busy}, 8'd1);
      do_erase(4'd8, 4'd0, "oob_e");
      step();
`endif
      req_valid = 1'b1;
      req_x     = 4'd7;
      req_y     = 4'd5;
      step();
      req_valid = 1'b0;
      chk("edge req_err", {7'd0, req_err}, 8'd0);
      chk("edge busy", {7'd0, busy}, 8'd1);
      do_erase(4'd7, 4'd5, "edge_e");
      step();
      chk("edge busy_after", {7'd0, busy}, 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
